// File: rtl/calc_delta_multi_pkg.sv
// Shared types for the multi-channel angle delta calculator: FSM state encoding and direction codes.
package calc_delta_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SUB     = 3'd2,
    SEL     = 3'd3,
    REPORT  = 3'd4
  } state_t;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

endpackage

// File: rtl/calc_delta_multi_if.sv
// Command-side bundle of the delta calculator: start/mask/deadband/angles in, per-channel results out.
interface calc_delta_multi_if #(
  parameter int ANGLE_W = 12,
  parameter int NUM_CH  = 4
);
  logic                      enable_calc;
  logic [NUM_CH-1:0]         ch_enable;
  logic [ANGLE_W-1:0]        deadband;
  logic [NUM_CH*ANGLE_W-1:0] target_angle;
  logic [NUM_CH*ANGLE_W-1:0] current_angle;
  logic [NUM_CH-1:0]         dir_shortest;
  logic [NUM_CH*ANGLE_W-1:0] delta_angle;
  logic [NUM_CH-1:0]         in_deadband;
  logic                      busy;
  logic                      calc_updated;

  modport master (
    output enable_calc, ch_enable, deadband, target_angle, current_angle,
    input  dir_shortest, delta_angle, in_deadband, busy, calc_updated
  );

  modport slave (
    input  enable_calc, ch_enable, deadband, target_angle, current_angle,
    output dir_shortest, delta_angle, in_deadband, busy, calc_updated
  );
endinterface

// File: rtl/angle_wrap_select.sv
// Picks the shorter way round the circle for a wrapped difference d = tgt - cur.
// Combinational, zero latency, no flow control; a half-turn tie resolves to CCW.
module angle_wrap_select
  import calc_delta_pkg::*;
#(
  parameter int ANGLE_W = 12
) (
  input  logic [ANGLE_W-1:0] d,
  output logic [ANGLE_W-1:0] delta,
  output logic               dir
);

  localparam logic [ANGLE_W-1:0] HALF = {1'b1, {(ANGLE_W-1){1'b0}}};

  always_comb begin
    delta = '0;
    dir   = DIR_CCW;
    if (d == '0) begin
      delta = '0;
      dir   = DIR_CCW;
    end else if (d < HALF) begin
      delta = d;
      dir   = DIR_CW;
    end else begin
      delta = '0 - d;
      dir   = DIR_CCW;
    end
  end

endmodule

// File: rtl/calc_delta_multi.sv
// Time-multiplexed shortest-path delta for NUM_CH channels; results publish together 2+2*NUM_CH edges after start.
// No backpressure: start is only honoured in IDLE, requests while busy are dropped.
module calc_delta_multi
  import calc_delta_pkg::*;
#(
  parameter int ANGLE_W = 12,
  parameter int NUM_CH  = 4
) (
  input logic               clock,
  input logic               reset_n,
  calc_delta_multi_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t                    state;
  logic [IDX_W-1:0]          ch_idx;
  logic [ANGLE_W-1:0]        tgt_q [NUM_CH];
  logic [ANGLE_W-1:0]        cur_q [NUM_CH];
  logic [ANGLE_W-1:0]        db_q;
  logic [NUM_CH-1:0]         en_q;
  logic [ANGLE_W-1:0]        d_q;
  logic [ANGLE_W-1:0]        sh_delta [NUM_CH];
  logic                      sh_dir [NUM_CH];
  logic [NUM_CH*ANGLE_W-1:0] delta_q;
  logic [NUM_CH-1:0]         dir_q;
  logic [NUM_CH-1:0]         inb_q;
  logic                      upd_q;
  logic [ANGLE_W-1:0]        sel_delta;
  logic                      sel_dir;

  // One selector serves every channel; d_q holds the channel currently in flight.
  angle_wrap_select #(.ANGLE_W(ANGLE_W)) u_sel (
    .d     (d_q),
    .delta (sel_delta),
    .dir   (sel_dir)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ch_idx  <= '0;
      db_q    <= '0;
      en_q    <= '0;
      d_q     <= '0;
      delta_q <= '0;
      dir_q   <= '0;
      inb_q   <= '0;
      upd_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i]    <= '0;
        cur_q[i]    <= '0;
        sh_delta[i] <= '0;
        sh_dir[i]   <= 1'b0;
      end
    end else begin
      upd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable_calc) state <= CAPTURE;
        end
        CAPTURE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            tgt_q[i] <= bus.target_angle[i*ANGLE_W +: ANGLE_W];
            cur_q[i] <= bus.current_angle[i*ANGLE_W +: ANGLE_W];
          end
          db_q   <= bus.deadband;
          en_q   <= bus.ch_enable;
          ch_idx <= '0;
          state  <= SUB;
        end
        SUB: begin
          d_q   <= tgt_q[ch_idx] - cur_q[ch_idx];
          state <= SEL;
        end
        SEL: begin
          sh_delta[ch_idx] <= sel_delta;
          sh_dir[ch_idx]   <= sel_dir;
          if (ch_idx == LAST_IDX) begin
            state <= REPORT;
          end else begin
            ch_idx <= ch_idx + IDX_W'(1);
            state  <= SUB;
          end
        end
        REPORT: begin
          // Masked channels keep whatever the last run that covered them left behind.
          for (int i = 0; i < NUM_CH; i++) begin
            if (en_q[i]) begin
              delta_q[i*ANGLE_W +: ANGLE_W] <= sh_delta[i];
              dir_q[i]                      <= sh_dir[i];
              inb_q[i]                      <= (sh_delta[i] <= db_q);
            end
          end
          upd_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.delta_angle  = delta_q;
  assign bus.dir_shortest = dir_q;
  assign bus.in_deadband  = inb_q;
  assign bus.calc_updated = upd_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_calc_delta_multi.sv
// Randomized bench for calc_delta_multi with a cycle-level reference model and a per-cycle comparator.
module tb_calc_delta_multi;

  localparam int AW   = 12;
  localparam int NC   = 4;
  localparam int LAT  = 2 + 2 * NC;
  localparam int FULL = 1 << AW;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  calc_delta_multi_if #(.ANGLE_W(AW), .NUM_CH(NC)) bus ();

  calc_delta_multi #(.ANGLE_W(AW), .NUM_CH(NC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: snapshot on the edge after the accepted start, publish LAT edges after it.
  logic [NC*AW-1:0] m_delta = '0;
  logic [NC-1:0]    m_dir   = '0;
  logic [NC-1:0]    m_inb   = '0;
  logic             m_upd   = 1'b0;
  logic             m_busy  = 1'b0;
  bit               m_act   = 1'b0;
  int               m_cnt   = 0;
  int               snap_t [NC];
  int               snap_c [NC];
  int               snap_db;
  logic [NC-1:0]    snap_en;
  int               cw, ccw, dl;
  logic             dr;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 0; m_cnt = 0; m_delta = '0; m_dir = '0; m_inb = '0; m_upd = 0; m_busy = 0;
    end else begin
      m_upd = 0;
      if (!m_act) begin
        if (bus.enable_calc === 1'b1) begin
          m_act = 1;
          m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 1) begin
          for (int i = 0; i < NC; i++) begin
            snap_t[i] = int'(bus.target_angle[i*AW +: AW]);
            snap_c[i] = int'(bus.current_angle[i*AW +: AW]);
          end
          snap_db = int'(bus.deadband);
          snap_en = bus.ch_enable;
        end
        if (m_cnt == LAT) begin
          for (int i = 0; i < NC; i++) begin
            if (snap_en[i]) begin
              cw  = (snap_t[i] - snap_c[i] + FULL) % FULL;
              ccw = (snap_c[i] - snap_t[i] + FULL) % FULL;
              if (cw < ccw) begin dl = cw;  dr = 1'b0; end
              else          begin dl = ccw; dr = 1'b1; end
              m_delta[i*AW +: AW] = AW'(dl);
              m_dir[i] = dr;
              m_inb[i] = (dl <= snap_db);
            end
          end
          m_upd = 1;
          m_act = 0;
        end
      end
      m_busy = m_act;
    end
  end

  always @(negedge clock) begin
    chk("cmp_delta", 64'(bus.delta_angle), 64'(m_delta));
    chk("cmp_dir", 64'(bus.dir_shortest), 64'(m_dir));
    chk("cmp_inb", 64'(bus.in_deadband), 64'(m_inb));
    chk("cmp_busy", 64'(bus.busy), 64'(m_busy));
    chk("cmp_upd", 64'(bus.calc_updated), 64'(m_upd));
  end

  function automatic int dlt(int ch);
    logic [NC*AW-1:0] v;
    v = bus.delta_angle;
    return int'(v[ch*AW +: AW]);
  endfunction

  task automatic set_ch(int ch, int t, int c);
    bus.target_angle[ch*AW +: AW]  = AW'(t);
    bus.current_angle[ch*AW +: AW] = AW'(c);
  endtask

  // Starts a run, then counts edges until calc_updated (bounded) and how many samples saw busy.
  task automatic run(output int lat, output int hi);
    @(posedge clock); #1 bus.enable_calc = 1'b1;
    @(posedge clock); #1 bus.enable_calc = 1'b0;
    lat = 0;
    hi  = 0;
    if (bus.busy) hi++;
    while (bus.calc_updated !== 1'b1 && lat < 50) begin
      @(posedge clock); #1;
      lat++;
      if (bus.busy) hi++;
    end
  endtask

  int lat, hi, pulses, first, t1, t2, cyc;

  initial begin
    bus.enable_calc   = 1'b0;
    bus.ch_enable     = '0;
    bus.deadband      = '0;
    bus.target_angle  = '0;
    bus.current_angle = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_delta", 64'(bus.delta_angle), 64'd0);
    chk("rst_dir", 64'(bus.dir_shortest), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_upd", 64'(bus.calc_updated), 64'd0);

    // Basic and wrap-around directions
    bus.ch_enable = 4'hF;
    set_ch(0, 100, 50); set_ch(1, 50, 100); set_ch(2, 10, 4000); set_ch(3, 4000, 10);
    run(lat, hi);
    chk("lat_basic", 64'(lat), 64'(LAT));
    chk("busy_cycles", 64'(hi), 64'(LAT));
    chk("ch0_delta", 64'(dlt(0)), 64'd50);
    chk("ch1_delta", 64'(dlt(1)), 64'd50);
    chk("ch2_delta", 64'(dlt(2)), 64'd106);
    chk("ch3_delta", 64'(dlt(3)), 64'd106);
    chk("dir_basic", 64'(bus.dir_shortest), 64'(4'b1010));

    // Half-turn tie, zero delta, one-step wrap
    set_ch(0, 2048, 0); set_ch(1, 777, 777); set_ch(2, 0, 4095); set_ch(3, 1, 2);
    run(lat, hi);
    chk("tie_delta", 64'(dlt(0)), 64'd2048);
    chk("zero_delta", 64'(dlt(1)), 64'd0);
    chk("wrap1_delta", 64'(dlt(2)), 64'd1);
    chk("dir_bound", 64'(bus.dir_shortest), 64'(4'b1011));

    // Deadband edges
    bus.deadband = 12'd20;
    set_ch(0, 115, 100); set_ch(1, 120, 100); set_ch(2, 121, 100); set_ch(3, 100, 121);
    run(lat, hi);
    chk("inb_edges", 64'(bus.in_deadband), 64'(4'b0011));
    chk("db21_delta", 64'(dlt(3)), 64'd21);

    // Mask: ch1 and ch3 hold their previous results
    bus.ch_enable = 4'b0101;
    set_ch(0, 300, 100); set_ch(1, 5, 9); set_ch(2, 100, 300); set_ch(3, 7, 7);
    run(lat, hi);
    chk("lat_mask", 64'(lat), 64'(LAT));
    chk("mask_ch0", 64'(dlt(0)), 64'd200);
    chk("mask_ch1", 64'(dlt(1)), 64'd20);
    chk("mask_ch3", 64'(dlt(3)), 64'd21);
    chk("mask_inb", 64'(bus.in_deadband), 64'(4'b0010));
    bus.ch_enable = 4'h0;
    run(lat, hi);
    chk("lat_mask0", 64'(lat), 64'(LAT));

    // Inputs change and start re-pulses mid-run
    bus.ch_enable = 4'hF;
    bus.deadband  = 12'd0;
    set_ch(0, 1000, 900); set_ch(1, 900, 1000); set_ch(2, 3000, 0); set_ch(3, 0, 0);
    @(posedge clock); #1 bus.enable_calc = 1'b1;
    @(posedge clock); #1 bus.enable_calc = 1'b0;
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock); #1;
      if (k == 3) begin set_ch(0, 5, 5); set_ch(1, 5, 5); set_ch(2, 5, 5); set_ch(3, 9, 5); end
      if (k == 5) bus.enable_calc = 1'b1;
      if (k == 6) bus.enable_calc = 1'b0;
      if (bus.calc_updated === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("midrun_pulses", 64'(pulses), 64'd1);
    chk("midrun_lat", 64'(first), 64'(LAT));
    chk("midrun_ch0", 64'(dlt(0)), 64'd100);
    chk("midrun_ch2", 64'(dlt(2)), 64'd1096);
    chk("midrun_dir", 64'(bus.dir_shortest), 64'(4'b1110));

    // Reset mid-run
    @(posedge clock); #1 bus.enable_calc = 1'b1;
    @(posedge clock); #1 bus.enable_calc = 1'b0;
    repeat (6) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_delta", 64'(bus.delta_angle), 64'd0);
    chk("arst_dir", 64'(bus.dir_shortest), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clock); #1;
      if (bus.calc_updated === 1'b1) pulses++;
    end
    chk("arst_nopulse", 64'(pulses), 64'd0);
    set_ch(0, 10, 4000);
    run(lat, hi);
    chk("arst_lat", 64'(lat), 64'(LAT));
    chk("arst_ch0", 64'(dlt(0)), 64'd106);

    // Start held high: back-to-back runs
    @(posedge clock); #1 bus.enable_calc = 1'b1;
    t1 = -1; t2 = -1; cyc = 0;
    while (t2 < 0 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (bus.calc_updated === 1'b1) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
    end
    bus.enable_calc = 1'b0;
    chk("held_period", 64'(t2 - t1), 64'(2 * NC + 3));
    repeat (15) @(posedge clock);

    // Random runs, checked by the per-cycle comparator
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NC; i++) begin
        t1 = int'($urandom_range(0, FULL - 1));
        if ($urandom_range(0, 1) == 1) t2 = (t1 + int'($urandom_range(0, 60)) - 30 + FULL) % FULL;
        else                           t2 = int'($urandom_range(0, FULL - 1));
        set_ch(i, t1, t2);
      end
      bus.ch_enable = NC'($urandom_range(0, (1 << NC) - 1));
      bus.deadband  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, FULL - 1))
                                                  : AW'($urandom_range(0, 40));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      run(lat, hi);
      chk("rand_lat", 64'(lat), 64'(LAT));
    end

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
